// File: rtl/pc_fetch.sv
// Program counter / fetch sequencer feeding the branch-target LUT (IDLE -> RUN -> HALT).
// Optional PC_FETCH_CYCLE_COUNT_EN adds a saturating RUN-cycle counter output.
module pc_fetch #(
    parameter int PC_W     = 16,
    parameter int LUT_AW   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              branch_en,
    input  logic              branch_cond,
    input  logic [LUT_AW-1:0] branch_idx,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [PC_W-1:0]   lut_target,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_valid,
    output logic              busy,
    output logic              done
`ifdef PC_FETCH_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            done_q, done_d;

    assign lut_addr    = branch_idx;
    assign pc          = pc_q;
    assign busy        = (state_q == S_RUN);
    assign fetch_valid = (state_q == S_RUN);
    assign done        = done_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = PC_RST;
                end
            end
            S_RUN: begin
                // Stall masks halt/branch; they are re-evaluated once it drops.
                if (stall) begin
                    pc_d = pc_q;
                end else if (halt_req) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end else if (branch_en && branch_cond) begin
                    pc_d = lut_target;
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = PC_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

`ifdef PC_FETCH_CYCLE_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_RUN) begin
            if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
        end else if (start) begin
            cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 32'd0;
        else       cnt_q <= cnt_d;
    end

    assign cycle_count = cnt_q;
`endif

endmodule
